// File: rtl/hdmi_video_timing.sv
// Raster timing generator with built-in test patterns. Produces registered,
// mutually aligned sync, data-enable, position and RGB outputs for TMDS encoders.
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o
);

  localparam logic [11:0] HActive    = 12'(H_ACTIVE);
  localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HLast      = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VActive    = 12'(V_ACTIVE);
  localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VLast      = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BarWLast   = 12'(H_ACTIVE / 8 - 1);

  // Raster and pattern state
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic [2:0]  bar_q, bar_d;
  logic [11:0] bar_pix_q, bar_pix_d;
  logic [1:0]  pat_q, pat_d;

  // Registered outputs
  logic        de_q, hsync_q, vsync_q, fs_q;
  logic [11:0] x_q, y_q;
  logic [23:0] rgb_q;

  // Combinational view of the pixel at (h_q, v_q)
  logic        first_pix;
  logic [1:0]  pat_cur;
  logic        de_c, hsync_c, vsync_c;
  logic [23:0] bar_rgb, rgb_c;

  assign first_pix = (h_q == 12'd0) && (v_q == 12'd0);
  // The pattern chosen at pixel (0,0) already applies to that pixel.
  assign pat_cur   = first_pix ? pat_sel_i : pat_q;

  // Counter, bar counter and pattern latch next-state
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    bar_d     = bar_q;
    bar_pix_d = bar_pix_q;
    pat_d     = pat_q;
    if (en_i) begin
      if (first_pix) begin
        pat_d = pat_sel_i;
      end
      if (h_q == HLast) begin
        h_d       = 12'd0;
        bar_d     = 3'd0;
        bar_pix_d = 12'd0;
        v_d       = (v_q == VLast) ? 12'd0 : v_q + 12'd1;
      end else begin
        h_d = h_q + 12'd1;
        // Bar index advances every BAR_W pixels and sticks at the last bar.
        if (bar_pix_q == BarWLast) begin
          bar_pix_d = 12'd0;
          if (bar_q != 3'd7) begin
            bar_d = bar_q + 3'd1;
          end
        end else begin
          bar_pix_d = bar_pix_q + 12'd1;
        end
      end
    end
  end

  // Colour bar lookup
  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_q)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Sync, data-enable and pattern pixel for the current position
  always_comb begin
    de_c    = (h_q < HActive) && (v_q < VActive);
    hsync_c = ((h_q >= HSyncStart) && (h_q < HSyncEnd)) ? HS_POL : ~HS_POL;
    // Depends on v only, so it can change solely across a line wrap.
    vsync_c = ((v_q >= VSyncStart) && (v_q < VSyncEnd)) ? VS_POL : ~VS_POL;
    rgb_c   = 24'h000000;
    unique case (pat_cur)
      2'd0: rgb_c = bar_rgb;
      2'd1: rgb_c = solid_rgb_i;
      2'd2: rgb_c = (h_q[4] ^ v_q[4]) ? 24'hFFFFFF : 24'h000000;
      2'd3: rgb_c = {3{h_q[7:0]}};
      default: rgb_c = 24'h000000;
    endcase
    if (!de_c) begin
      rgb_c = 24'h000000;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q       <= 12'd0;
      v_q       <= 12'd0;
      bar_q     <= 3'd0;
      bar_pix_q <= 12'd0;
      pat_q     <= 2'd0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_q     <= bar_d;
      bar_pix_q <= bar_pix_d;
      pat_q     <= pat_d;
    end
  end

  // Output registers; all capture the same pixel so nothing is skewed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      rgb_q   <= 24'h000000;
    end else if (en_i) begin
      de_q    <= de_c;
      hsync_q <= hsync_c;
      vsync_q <= vsync_c;
      fs_q    <= first_pix;
      x_q     <= h_q;
      y_q     <= v_q;
      rgb_q   <= rgb_c;
    end
  end

  assign de_o          = de_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = fs_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign red_o         = rgb_q[23:16];
  assign green_o       = rgb_q[15:8];
  assign blue_o        = rgb_q[7:0];

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Raster timing and test-pattern source that feeds the per-channel TMDS encoders. Generates horizontal and vertical counters, sync and data-enable, and 8-bit RGB pixel data from a built-in pattern generator. All outputs are registered and mutually aligned, so each one connects directly to encoder inputs: RGB to VD, {vsync,hsync} to CD of channel 0, de to VDE.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel advance enable; low freezes counters and all outputs
- pat_sel  in  2  pattern: 0 colour bars, 1 solid, 2 checkerboard, 3 ramp
- solid_rgb  in  24  {R,G,B} used when pat_sel=1
- de  out  1  data enable (active video)
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- x  out  12  horizontal counter of the presented pixel
- y  out  12  vertical counter of the presented pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- red, green, blue  out  8 each  pixel data; 0 whenever de=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default).
- Internal counters h in 0..H_TOTAL-1, v in 0..V_TOTAL-1. On every clk edge with en=1: outputs are registered from the current (h,v), then h increments; at h=H_TOTAL-1, h wraps to 0 and v increments; at v=V_TOTAL-1 with h=H_TOTAL-1, both wrap to 0.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; vsync is line-based and changes only alongside h=0.
- x = h, y = v, including during blanking. frame_start = (h==0 && v==0).
- The active pattern is latched from pat_sel only at h=0,v=0; a mid-frame change takes effect on the next frame. solid_rgb is sampled every pixel.
- Colour bars: 8 bars of width BAR_W = H_ACTIVE/8 (integer). Bar index comes from a bar counter cleared at h=0 that advances every BAR_W pixels and saturates at 7 (no divider). Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Checkerboard: white if x[4]^y[4], else black (16x16 squares).
- Ramp: R=G=B=x[7:0].

## Timing
- Reset (async assert, any time including mid-frame): h=v=0, bar counter=0, latched pattern=0, de=0, frame_start=0, x=y=0, RGB=0, hsync=~HS_POL, vsync=~VS_POL.
- Latency: one clock. The first en=1 edge after reset release presents pixel (0,0): de=1, frame_start=1, x=y=0, and RGB from pattern 0 (white under colour bars).
- en=0: no state changes; outputs hold their last values. The encoder must be clocked with the same enable or run at pixel rate with en tied high.
- hsync, vsync, de, x, y and RGB always describe the same pixel; no skew between them.
- Frame period is H_TOTAL*V_TOTAL enabled cycles (420000 default); frame_start pulses exactly once per frame.

## Test plan
- Reset check: hold rst_n=0, then release with en=0 -> de=0, hsync=1, vsync=1, RGB=0, x=y=0 until en rises.
- Line timing with default parameters and en=1: de high for x 0..639; hsync low exactly for x 656..751; x wraps 799->0 while y increments.
- Frame timing: vsync low for y 490..491 only. frame_start pulses are 420000 cycles apart. y wraps 524->0.
- Colour bars: x=0 -> FFFFFF, x=80 -> FFFF00, x=639 -> 000000, x=640 -> 000000 with de=0.
- Pattern switch: change pat_sel 0->3 at y=100 -> bars continue to frame end; the next frame shows ramp, with x=200 giving C8C8C8.
- Stall and mid-frame reset: toggle en low for 5 cycles at x=300 -> outputs hold, then resume at x=301. Pulse rst_n low at y=200 -> reset values appear immediately, and after release the first enabled pixel is (0,0) with frame_start=1.
